mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer that shares one single-port `memory` instance between the fetch stage (instruction port, read-only) and the memory stage (data port, load/store). It registers the winner's request, drives the memory's addr/rd_wr/op_en/wr_data for one cycle, and waits a fixed memory latency. It then returns the registered read data with a one-cycle ack pulse to the winner. Data port has priority; a starvation counter guarantees fetch forward progress.

Parameters:
WD_SIZE, PARAMS_pkg::WD_SIZE (32), width of address and data buses
MEM_LAT, 1, cycles from the mem_op_en cycle to valid mem_rd_data (range 1..7)
MAX_WAIT, 3, consecutive data-port wins over a pending fetch before fetch is forced (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  WD_SIZE  fetch byte address
if_ack  out  1  one-cycle completion pulse to fetch
if_rd_data  out  WD_SIZE  instruction word, valid while if_ack=1
dm_req  in  1  data request, held until dm_ack
dm_rd_wr  in  1  1=write (store), 0=read (load)
dm_addr  in  WD_SIZE  data byte address
dm_wr_data  in  WD_SIZE  store data
dm_ack  out  1  one-cycle completion pulse to data port
dm_rd_data  out  WD_SIZE  load data, valid while dm_ack=1
dm_err  out  1  misaligned-access pulse, coincident with dm_ack; tied 0 when the optional feature is disabled
mem_addr  out  WD_SIZE  to memory.addr
mem_rd_wr  out  1  to memory.rd_wr, 1=write
mem_op_en  out  1  to memory.op_en, one-cycle strobe
mem_wr_data  out  WD_SIZE  to memory.wr_data
mem_rd_data  in  WD_SIZE  from memory.rd_data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE and starve_cnt=0. All outputs are 0: acks, rd_data, err, mem_* and busy. Any in-flight access is abandoned with no ack. Reset deassertion is synchronised externally.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if no request is pending, stay in IDLE.
  - If only one port requests, grant it.
  - If both request, grant data, unless starve_cnt==MAX_WAIT, in which case grant fetch.
  - On a grant, latch grant id, address, rd_wr (fetch is always read) and wr_data. Next state is ACCESS.
- ACCESS (1 cycle): mem_op_en=1; mem_addr, mem_rd_wr and mem_wr_data are driven from the latched registers. Load lat_cnt=MEM_LAT-1. Next state is WAIT.
- WAIT: mem_op_en=0 and mem_* hold their values.
  - When lat_cnt==0: capture mem_rd_data into the granted port's rd_data register and go to RESP.
  - Otherwise decrement lat_cnt.
- RESP (1 cycle): the granted port's ack=1. Next state is always IDLE. The requester may drop req or present a new request in the following cycle.
- Latency: req first seen in IDLE at cycle N gives:
  - mem_op_en at N+1
  - capture at N+1+MEM_LAT
  - ack at N+2+MEM_LAT (N+3 for default MEM_LAT=1)
  - Reads and writes use identical timing.
  - Minimum request-to-request spacing for one port is MEM_LAT+3 cycles.
- rd_data registers keep their last value outside ack; on write completions they are undefined (hold previous).
- Starvation counter (width 4):
  - Increments when data is granted while if_req=1, saturating at MAX_WAIT.
  - Clears when fetch is granted.
  - Unchanged otherwise.
- Request attributes are sampled only in IDLE. Changes while waiting are ignored until the next arbitration.
- Requester dropping req before ack is a protocol violation: the access completes and ack still pulses.
- Simultaneous reset and ack: reset wins.

Optional Feature:
MEM_ARB_MISALIGN_CHECK_EN
- Defined: in IDLE, a granted data request with dm_addr[1:0]!=0 skips ACCESS/WAIT and goes directly to RESP. It pulses dm_ack and dm_err together, with no memory strobe. Fetch requests with if_addr[1:0]!=0 are still issued unchecked.
- Undefined: no check is performed, dm_err is constant 0, and all requests reach memory.

Decomposition:
- PARAMS_pkg gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP} arb_state_t
  - constants ARB_GNT_IF=1'b0 and ARB_GNT_DM=1'b1
  - constant MEM_WR=1'b1
- Single module with no sub-module: the arbitration and starvation logic is too small to split.

Test Plan:
1. Idle, if_req with if_addr=0x8 and mem_rd_data=0x00500093 -> mem_op_en at N+1 with mem_addr=0x8 and mem_rd_wr=0; if_ack=1 and if_rd_data=0x00500093 at N+3; busy high N+1..N+3.
2. if_req and dm_req (read, 0x10) asserted in the same cycle -> data served first (dm_ack at N+3); fetch issued next with mem_op_en at N+5; starve_cnt=1 then 0.
3. MAX_WAIT=2, if_req held and dm_req re-asserted immediately after each ack -> grant order DM, DM, IF, DM; fetch never waits more than 2 data accesses.
4. Store 0xDEADBEEF to 0x14, then load 0x14 -> the first access has mem_rd_wr=1 and mem_wr_data=0xDEADBEEF; the load returns dm_rd_data=0xDEADBEEF with dm_ack.
5. reset_n pulled low during WAIT -> outputs immediately 0 and state IDLE; no ack ever issued for that request; a fresh request afterwards completes normally.
6. With MEM_ARB_MISALIGN_CHECK_EN, dm read at 0x13 -> dm_ack=dm_err=1 at N+1 and mem_op_en never asserted; without the macro -> normal access at 0x13 and dm_err=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : PARAMS_pkg
// Description : Shared widths, arbiter state encoding and grant/command
//               constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package PARAMS_pkg;

  // Address and data bus width shared by the core and the memory.
  localparam int WD_SIZE = 32;

  // Width of the fetch starvation counter and of the latency down-counter.
  localparam int STARVE_W = 4;
  localparam int LAT_W    = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  // Grant identifiers.
  localparam logic ARB_GNT_IF = 1'b0;
  localparam logic ARB_GNT_DM = 1'b1;

  // Memory command encoding on rd_wr.
  localparam logic MEM_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the fetch port, data port, memory port and status
//               signals around the memory arbiter. The slave modport is the
//               arbiter's view; master is the view of the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int WD_SIZE = PARAMS_pkg::WD_SIZE
) ();

  // Fetch (instruction) port, read-only.
  logic               if_req;
  logic [WD_SIZE-1:0] if_addr;
  logic               if_ack;
  logic [WD_SIZE-1:0] if_rd_data;

  // Data (load/store) port.
  logic               dm_req;
  logic               dm_rd_wr;
  logic [WD_SIZE-1:0] dm_addr;
  logic [WD_SIZE-1:0] dm_wr_data;
  logic               dm_ack;
  logic [WD_SIZE-1:0] dm_rd_data;
  logic               dm_err;

  // Single-port memory side.
  logic [WD_SIZE-1:0] mem_addr;
  logic               mem_rd_wr;
  logic               mem_op_en;
  logic [WD_SIZE-1:0] mem_wr_data;
  logic [WD_SIZE-1:0] mem_rd_data;

  // Status.
  logic               busy;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rd_data,
    input  dm_req, dm_rd_wr, dm_addr, dm_wr_data,
    output dm_ack, dm_rd_data, dm_err,
    output mem_addr, mem_rd_wr, mem_op_en, mem_wr_data,
    input  mem_rd_data,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rd_data,
    output dm_req, dm_rd_wr, dm_addr, dm_wr_data,
    input  dm_ack, dm_rd_data, dm_err,
    input  mem_addr, mem_rd_wr, mem_op_en, mem_wr_data,
    output mem_rd_data,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the fetch port and the
//               data port. The winner's request is registered, issued to the
//               memory as a one-cycle strobe, the fixed memory latency is
//               waited out, and the result is returned with a one-cycle ack.
//               Data has priority; a starvation counter forces a pending
//               fetch through after MAX_WAIT consecutive data wins.
//               Optional macro MEM_ARB_MISALIGN_CHECK_EN: misaligned data
//               accesses are answered at once with dm_ack + dm_err and never
//               reach the memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import PARAMS_pkg::*;
#(
  parameter int WD_SIZE  = PARAMS_pkg::WD_SIZE,
  parameter int MEM_LAT  = 1,   // 1..7
  parameter int MAX_WAIT = 3    // 1..15
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);
  localparam logic [LAT_W-1:0]    LAT_LOAD_C = LAT_W'(MEM_LAT - 1);

  arb_state_t           state_q,      state_d;
  logic                 gnt_q,        gnt_d;
  logic [WD_SIZE-1:0]   addr_q,       addr_d;
  logic                 rd_wr_q,      rd_wr_d;
  logic [WD_SIZE-1:0]   wr_data_q,    wr_data_d;
  logic [LAT_W-1:0]     lat_cnt_q,    lat_cnt_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [WD_SIZE-1:0]   if_rd_data_q, if_rd_data_d;
  logic [WD_SIZE-1:0]   dm_rd_data_q, dm_rd_data_d;

  logic grant_valid;
  logic grant_dm;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic err_q, err_d;
  logic dm_misaligned;

  assign dm_misaligned = (bus.dm_addr[1:0] != 2'b00);
`endif

  // Arbitration: data wins unless the fetch port has been starved MAX_WAIT times.
  always_comb begin
    grant_valid = 1'b0;
    grant_dm    = 1'b0;
    if (bus.dm_req && bus.if_req) begin
      grant_valid = 1'b1;
      grant_dm    = (starve_cnt_q != MAX_WAIT_C);
    end else if (bus.dm_req) begin
      grant_valid = 1'b1;
      grant_dm    = 1'b1;
    end else if (bus.if_req) begin
      grant_valid = 1'b1;
      grant_dm    = 1'b0;
    end
  end

  // Next-state logic for the sequencer, request latches and result registers.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    rd_wr_d      = rd_wr_q;
    wr_data_d    = wr_data_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rd_data_d = if_rd_data_q;
    dm_rd_data_d = dm_rd_data_q;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    err_d        = err_q;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d = ARB_ACCESS;
          if (grant_dm) begin
            gnt_d     = ARB_GNT_DM;
            addr_d    = bus.dm_addr;
            rd_wr_d   = bus.dm_rd_wr;
            wr_data_d = bus.dm_wr_data;
            // Only a data win over a waiting fetch counts as starvation.
            if (bus.if_req && (starve_cnt_q < MAX_WAIT_C)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end else begin
            gnt_d        = ARB_GNT_IF;
            addr_d       = bus.if_addr;
            rd_wr_d      = ~MEM_WR;
            wr_data_d    = '0;
            starve_cnt_d = '0;
          end
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          err_d = 1'b0;
          // Misaligned data accesses are answered directly without a strobe.
          if (grant_dm && dm_misaligned) begin
            err_d   = 1'b1;
            state_d = ARB_RESP;
          end
`endif
        end
      end

      ARB_ACCESS: begin
        lat_cnt_d = LAT_LOAD_C;
        state_d   = ARB_WAIT;
      end

      ARB_WAIT: begin
        if (lat_cnt_q == '0) begin
          // Writes return nothing, so the read-data registers keep their value.
          if (rd_wr_q != MEM_WR) begin
            if (gnt_q == ARB_GNT_DM) begin
              dm_rd_data_d = bus.mem_rd_data;
            end else begin
              if_rd_data_d = bus.mem_rd_data;
            end
          end
          state_d = ARB_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= ARB_GNT_IF;
      addr_q       <= '0;
      rd_wr_q      <= 1'b0;
      wr_data_q    <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rd_data_q <= '0;
      dm_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      rd_wr_q      <= rd_wr_d;
      wr_data_q    <= wr_data_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rd_data_q <= if_rd_data_d;
      dm_rd_data_q <= dm_rd_data_d;
    end
  end

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  // Error flag for the current data response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.dm_err = bus.dm_ack & err_q;
`else
  assign bus.dm_err = 1'b0;
`endif

  // Memory side is driven straight from the latched request; the strobe
  // exists only in ACCESS, so the address/data simply hold through WAIT.
  assign bus.mem_op_en   = (state_q == ARB_ACCESS);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd_wr   = rd_wr_q;
  assign bus.mem_wr_data = wr_data_q;

  assign bus.if_ack     = (state_q == ARB_RESP) && (gnt_q == ARB_GNT_IF);
  assign bus.dm_ack     = (state_q == ARB_RESP) && (gnt_q == ARB_GNT_DM);
  assign bus.if_rd_data = if_rd_data_q;
  assign bus.dm_rd_data = dm_rd_data_q;
  assign bus.busy       = (state_q != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               one-cycle-latency behavioural memory. Built with MAX_WAIT=2.
//               Honours MEM_ARB_MISALIGN_CHECK_EN for the misaligned case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .MEM_LAT  (1),
    .MAX_WAIT (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory, read data valid one cycle after op_en.
  logic [31:0] mem_model [0:63];

  always @(posedge clk) begin
    if (bus_if.mem_op_en) begin
      if (bus_if.mem_rd_wr) begin
        mem_model[bus_if.mem_addr[7:2]] <= bus_if.mem_wr_data;
      end else begin
        bus_if.mem_rd_data <= mem_model[bus_if.mem_addr[7:2]];
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full aligned data access starting in IDLE; ends back in IDLE.
  task automatic dm_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata_exp, input string tag);
    bus_if.dm_req     = 1'b1;
    bus_if.dm_rd_wr   = rw;
    bus_if.dm_addr    = addr;
    bus_if.dm_wr_data = wdata;
    tick();
    chk_eq({tag, "_op_en"}, bus_if.mem_op_en, 1'b1);
    chk_eq({tag, "_mem_addr"}, bus_if.mem_addr, addr);
    chk_eq({tag, "_mem_rd_wr"}, bus_if.mem_rd_wr, rw);
    if (rw) chk_eq({tag, "_mem_wr_data"}, bus_if.mem_wr_data, wdata);
    tick();
    chk_eq({tag, "_op_en_wait"}, bus_if.mem_op_en, 1'b0);
    chk_eq({tag, "_ack_early"}, bus_if.dm_ack, 1'b0);
    tick();
    chk_eq({tag, "_dm_ack"}, bus_if.dm_ack, 1'b1);
    chk_eq({tag, "_dm_err"}, bus_if.dm_err, 1'b0);
    if (!rw) chk_eq({tag, "_dm_rd_data"}, bus_if.dm_rd_data, rdata_exp);
    bus_if.dm_req = 1'b0;
    tick();
    chk_eq({tag, "_idle"}, bus_if.busy, 1'b0);
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[4];
    int n_both;
    logic saw_ack;

    for (int i = 0; i < 64; i++) mem_model[i] = 32'hA5A5_0000 | i;
    mem_model[2] = 32'h0050_0093;
    mem_model[4] = 32'h1111_2222;
    mem_model[5] = 32'h0000_0000;

    reset_n            = 1'b0;
    bus_if.if_req      = 1'b0;
    bus_if.if_addr     = '0;
    bus_if.dm_req      = 1'b0;
    bus_if.dm_rd_wr    = 1'b0;
    bus_if.dm_addr     = '0;
    bus_if.dm_wr_data  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", bus_if.busy, 1'b0);
    chk_eq("rst_op_en", bus_if.mem_op_en, 1'b0);
    chk_eq("rst_mem_addr", bus_if.mem_addr, 32'h0);
    chk_eq("rst_acks", {bus_if.if_ack, bus_if.dm_ack, bus_if.dm_err}, 32'h0);
    chk_eq("rst_if_rd", bus_if.if_rd_data, 32'h0);
    chk_eq("rst_dm_rd", bus_if.dm_rd_data, 32'h0);
    #3 reset_n = 1'b1;
    tick();

    // 1: single fetch.
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h8;
    chk_eq("t1_idle_busy", bus_if.busy, 1'b0);
    tick();
    chk_eq("t1_op_en", bus_if.mem_op_en, 1'b1);
    chk_eq("t1_mem_addr", bus_if.mem_addr, 32'h8);
    chk_eq("t1_mem_rd_wr", bus_if.mem_rd_wr, 1'b0);
    chk_eq("t1_busy1", bus_if.busy, 1'b1);
    tick();
    chk_eq("t1_op_en_wait", bus_if.mem_op_en, 1'b0);
    chk_eq("t1_ack_early", bus_if.if_ack, 1'b0);
    chk_eq("t1_busy2", bus_if.busy, 1'b1);
    tick();
    chk_eq("t1_if_ack", bus_if.if_ack, 1'b1);
    chk_eq("t1_dm_ack", bus_if.dm_ack, 1'b0);
    chk_eq("t1_if_rd", bus_if.if_rd_data, 32'h0050_0093);
    chk_eq("t1_busy3", bus_if.busy, 1'b1);
    bus_if.if_req = 1'b0;
    tick();
    chk_eq("t1_ack_pulse", bus_if.if_ack, 1'b0);
    chk_eq("t1_busy_end", bus_if.busy, 1'b0);

    // 2: simultaneous requests, data first then fetch.
    bus_if.if_req   = 1'b1;
    bus_if.if_addr  = 32'h8;
    bus_if.dm_req   = 1'b1;
    bus_if.dm_rd_wr = 1'b0;
    bus_if.dm_addr  = 32'h10;
    tick();
    chk_eq("t2_op_en_dm", bus_if.mem_op_en, 1'b1);
    chk_eq("t2_addr_dm", bus_if.mem_addr, 32'h10);
    tick();
    tick();
    chk_eq("t2_dm_ack", bus_if.dm_ack, 1'b1);
    chk_eq("t2_if_ack0", bus_if.if_ack, 1'b0);
    chk_eq("t2_dm_rd", bus_if.dm_rd_data, 32'h1111_2222);
    bus_if.dm_req = 1'b0;
    tick();
    chk_eq("t2_idle", bus_if.busy, 1'b0);
    tick();
    chk_eq("t2_op_en_if", bus_if.mem_op_en, 1'b1);
    chk_eq("t2_addr_if", bus_if.mem_addr, 32'h8);
    tick();
    tick();
    chk_eq("t2_if_ack", bus_if.if_ack, 1'b1);
    chk_eq("t2_if_rd", bus_if.if_rd_data, 32'h0050_0093);
    bus_if.if_req = 1'b0;
    tick();

    // 3: starvation bound with MAX_WAIT=2 -> DM, DM, IF, DM.
    exp_order = '{1, 1, 0, 1};
    n_both = 0;
    bus_if.if_req   = 1'b1;
    bus_if.if_addr  = 32'h8;
    bus_if.dm_req   = 1'b1;
    bus_if.dm_rd_wr = 1'b0;
    bus_if.dm_addr  = 32'h10;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      if (bus_if.dm_ack && bus_if.if_ack) n_both++;
      if (bus_if.dm_ack) order.push_back(1);
      else if (bus_if.if_ack) order.push_back(0);
    end
    bus_if.if_req = 1'b0;
    bus_if.dm_req = 1'b0;
    chk_eq("t3_grant_count", order.size(), 4);
    chk_eq("t3_both_acks", n_both, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) chk_eq($sformatf("t3_grant%0d", k), order[k], exp_order[k]);
    end
    tick();
    chk_eq("t3_idle", bus_if.busy, 1'b0);

    // 4: store then load back.
    dm_access(1'b1, 32'h14, 32'hDEAD_BEEF, 32'h0, "t4_st");
    dm_access(1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, "t4_ld");

    // 5: reset during WAIT abandons the access.
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h8;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk_eq("t5_busy", bus_if.busy, 1'b0);
    chk_eq("t5_op_en", bus_if.mem_op_en, 1'b0);
    chk_eq("t5_mem_addr", bus_if.mem_addr, 32'h0);
    chk_eq("t5_if_rd", bus_if.if_rd_data, 32'h0);
    chk_eq("t5_dm_rd", bus_if.dm_rd_data, 32'h0);
    bus_if.if_req = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    saw_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus_if.if_ack || bus_if.dm_ack) saw_ack = 1'b1;
    end
    chk_eq("t5_no_ack", saw_ack, 1'b0);
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h14;
    tick();
    chk_eq("t5_op_en_new", bus_if.mem_op_en, 1'b1);
    tick();
    tick();
    chk_eq("t5_if_ack", bus_if.if_ack, 1'b1);
    chk_eq("t5_if_rd_new", bus_if.if_rd_data, 32'hDEAD_BEEF);
    bus_if.if_req = 1'b0;
    tick();

    // 6: misaligned data read at 0x13.
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    bus_if.dm_req   = 1'b1;
    bus_if.dm_rd_wr = 1'b0;
    bus_if.dm_addr  = 32'h13;
    tick();
    chk_eq("t6_dm_ack", bus_if.dm_ack, 1'b1);
    chk_eq("t6_dm_err", bus_if.dm_err, 1'b1);
    chk_eq("t6_op_en", bus_if.mem_op_en, 1'b0);
    bus_if.dm_req = 1'b0;
    tick();
    chk_eq("t6_op_en_after", bus_if.mem_op_en, 1'b0);
    chk_eq("t6_err_pulse", bus_if.dm_err, 1'b0);
    chk_eq("t6_idle", bus_if.busy, 1'b0);
`else
    dm_access(1'b0, 32'h13, 32'h0, 32'h1111_2222, "t6_mis");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
